// File: rtl/shared_resource_pipeline.sv
// Valid/ready intake with a one-word hold register, an arbitrated fixed-latency shared
// resource, and a credit-gated DEPTH-entry result FIFO with synchronous flush.
module shared_resource_pipeline #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_arbiter_req,
  input  logic              i_arbiter_grant,
  output logic [DATA_W-1:0] o_resource_input,
  input  logic [DATA_W-1:0] i_resource_output
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] C_DEPTH = (AW+2)'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_hold, w_hold_nxt;
  logic [RES_LAT-1:0] r_track;
  logic [AW:0]        r_inflight, r_count, w_count_nxt;
  logic [AW-1:0]      r_wptr, r_rptr, w_rptr_nxt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_out_data, w_out_data_nxt;
  logic               r_out_valid;
  logic               w_credit, w_issue, w_accept, w_push, w_pop;

  // A request is only raised when a result slot is guaranteed; a pop this cycle earns no credit.
  assign w_credit         = ({1'b0, r_count} + {1'b0, r_inflight}) < C_DEPTH;
  assign o_arbiter_req    = (r_state == S_REQ) & w_credit & ~i_flush;
  assign w_issue          = o_arbiter_req & i_arbiter_grant;
  assign o_in_ready       = ((r_state == S_IDLE) | w_issue) & ~i_flush;
  assign w_accept         = i_in_valid & o_in_ready;
  assign o_resource_input = w_issue ? r_hold : {DATA_W{1'b0}};
  assign w_push           = r_track[RES_LAT-1] & ~i_flush;
  assign w_pop            = r_out_valid & i_out_ready & ~i_flush;
  assign o_out_valid      = r_out_valid;
  assign o_out_data       = r_out_data;

  // Hold register / FSM next state: flush dominates, accept refills, issue drains.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = {DATA_W{1'b0}};
    end else if (w_accept) begin
      w_state_nxt = S_REQ;
      w_hold_nxt  = i_in_data;
    end else if (w_issue) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and hold register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_hold  <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // In-flight tracker and its population count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_track    <= {RES_LAT{1'b0}};
      r_inflight <= {(AW+1){1'b0}};
    end else if (i_flush) begin
      r_track    <= {RES_LAT{1'b0}};
      r_inflight <= {(AW+1){1'b0}};
    end else begin
      r_track <= (r_track << 1'b1) | RES_LAT'(w_issue);
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // FIFO bookkeeping and next head value, so the head can be held in a register.
  always_comb begin
    w_count_nxt    = r_count;
    w_rptr_nxt     = r_rptr;
    w_out_data_nxt = {DATA_W{1'b0}};
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (w_pop) begin
      w_rptr_nxt = r_rptr + 1'b1;
    end else begin
      w_rptr_nxt = r_rptr;
    end
    if (w_count_nxt == {(AW+1){1'b0}}) begin
      w_out_data_nxt = {DATA_W{1'b0}};
    end else if (w_push && (w_count_nxt == {{AW{1'b0}}, 1'b1})) begin
      w_out_data_nxt = i_resource_output;
    end else begin
      w_out_data_nxt = r_mem[w_rptr_nxt];
    end
  end

  // FIFO pointers, count and registered head.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_count     <= {(AW+1){1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
    end else if (i_flush) begin
      r_wptr      <= {AW{1'b0}};
      r_rptr      <= {AW{1'b0}};
      r_count     <= {(AW+1){1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end else begin
        r_wptr <= r_wptr;
      end
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != {(AW+1){1'b0}});
      r_out_data  <= w_out_data_nxt;
    end
  end

  // FIFO storage; contents are only read once written, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_resource_output;
    end
  end
endmodule

// File: doc/shared_resource_pipeline.md
# shared_resource_pipeline

Parametrised pipeline stage that accepts words over a valid/ready handshake, obtains each word's result from a shared, arbitrated, fixed-latency resource, and buffers results in a DEPTH-entry output FIFO. Credit-based request gating guarantees the FIFO never overflows. A synchronous flush discards every word held, in flight or buffered. It sits between an upstream producer and downstream consumer, with one requester port on the system arbiter.

## Interface
- DATA_W, 32, width of data, resource_input and resource_output
- DEPTH, 4, output FIFO entries; power of two, ≥2
- RES_LAT, 2, cycles from grant to valid resource_output; ≥1
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  DATA_W  upstream word
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept this cycle
- flush  in  1  synchronous discard of all words, highest priority
- out_data  out  DATA_W  FIFO head; 0 when empty
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream pops head when out_valid & out_ready
- arbiter_req  out  1  request for the shared resource
- arbiter_grant  in  1  grant; meaningful only when arbiter_req is high
- resource_input  out  DATA_W  operand presented during the issue cycle; 0 otherwise
- resource_output  in  DATA_W  resource result, valid RES_LAT cycles after issue

## Operation
- Hold register (1 entry), FSM IDLE/REQ. IDLE: empty. REQ: holds one accepted word.
- Accept = in_valid & in_ready; word latched into hold, FSM → REQ.
- Credit: free = DEPTH − fifo_count − inflight_count; same-cycle pop not credited.
- arbiter_req = (state==REQ) & (free>0) & !flush. Combinational, no dependence on arbiter_grant.
- Issue = arbiter_req & arbiter_grant. resource_input = hold word in the issue cycle; 0 in all other cycles.
- Issue empties hold: FSM → IDLE, unless a new word is accepted the same cycle, in which case FSM stays REQ with the new word.
- in_ready = ((state==IDLE) | issue) & !flush. Accept and issue may coincide.
- In-flight tracker: RES_LAT-bit valid shift register, bit 0 set on issue. When the MSB is set, resource_output is written to the FIFO at that clock edge.
- inflight_count = popcount(tracker). It may be kept as a counter updated with ±1.
- FIFO: DEPTH entries; read/write pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged. A push into a full FIFO cannot occur because of credit gating. Verification asserts this.
- Flush (edge with flush=1):
  - hold cleared, FSM → IDLE
  - tracker cleared, so results returning later are ignored
  - FIFO pointers and count zeroed
  - grant and accept inputs ignored during the flush cycle
- Reset: same clearing as flush, applied asynchronously.

## Timing
- Output values while reset is high:
  - out_valid = 0, out_data = 0
  - arbiter_req = 0, resource_input = 0
  - in_ready = 1, unless flush is high
- Accept at edge T0 → arbiter_req high in cycle T0+1.
- Issue in cycle G:
  - resource_output sampled at the end of cycle G+RES_LAT
  - out_valid high in cycle G+RES_LAT+1
- Minimum latency from accept edge to out_valid: RES_LAT+2 cycles.
- Sustained throughput: 1 word/cycle with grant held high, out_ready=1 and DEPTH > RES_LAT+1.
- out_data and out_valid are registered state (FIFO head). in_ready, arbiter_req and resource_input are combinational.
- Reset deasserted mid-transaction: all prior words are lost. No req until a new accept.

## Test plan
- DATA_W=32, RES_LAT=2; resource model returns operand+1. Send 0x10, grant always high, out_ready=1:
  - arbiter_req high 1 cycle after accept
  - out_data=0x11 with out_valid high 4 cycles after the accept edge
- Backpressure, DEPTH=4, out_ready=0, stream 8 words:
  - exactly 4 issues occur
  - arbiter_req then held low, in_ready low after the 5th accept
  - out_ready=1 drains the words in order with no loss or duplication
- Grant withheld 5 cycles:
  - arbiter_req steady high, resource_input=0, in_ready=0
  - grant in cycle 6 → issue, and in_ready=1 in that same cycle
- Flush one cycle after an issue, with 2 words in the FIFO:
  - out_valid=0 next cycle
  - the returning result is not written
  - the next word is processed normally
- Continuous stream of 20 words, grant=1, out_ready=1:
  - one output per cycle after the initial latency
  - pointers wrap correctly past DEPTH
- Async reset asserted mid-stream, between edges:
  - out_valid and arbiter_req fall immediately
  - after release, only post-reset inputs appear at the output
